// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display paths: segment codes
// (a..g, active low, a is the MSB) and the all-off display words.
package seg7_pkg;

    localparam logic [6:0] SEG_0   = 7'b0000001;
    localparam logic [6:0] SEG_1   = 7'b1001111;
    localparam logic [6:0] SEG_2   = 7'b0010010;
    localparam logic [6:0] SEG_3   = 7'b0000110;
    localparam logic [6:0] SEG_4   = 7'b1001100;
    localparam logic [6:0] SEG_5   = 7'b0100100;
    localparam logic [6:0] SEG_6   = 7'b0100000;
    localparam logic [6:0] SEG_7   = 7'b0001111;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0000100;
    localparam logic [6:0] SEG_OFF = 7'b1111111;

    localparam logic [3:0]  ANODE_OFF = 4'b1111;
    localparam logic [11:0] DISP_OFF  = 12'hFFF;

endpackage

// File: rtl/seg7_decode.sv
// Nibble to active-low segment decode. Non-BCD nibbles (A-F) turn every
// segment off. Purely combinational; shared with the single-digit path.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    // Table lookup, anything outside 0-9 is dark
    always_comb begin
        seg_o = SEG_OFF;
        case (nib_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan4.sv
// Four-digit multiplexed seven-segment scan driver. A shadow copy of the
// BCD value and decimal points is scanned one digit per dwell period; the
// 12-bit display word is fully registered so no input reaches DISP
// combinationally.
module seg7_scan4
    import seg7_pkg::*;
#(
    parameter int T1MS     = 100000,
    parameter int SCAN_MS  = 1,
    parameter bit BLANK_LZ = 1'b1
)(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] VALUE,
    input  logic [3:0]  DP,
    input  logic        LOAD,
    output logic [11:0] DISP
);

    localparam int DWELL = T1MS * SCAN_MS;
    localparam int CNT_W = (DWELL > 2) ? $clog2(DWELL) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      val_q, val_d;
    logic [3:0]       dp_q, dp_d;
    logic [11:0]      disp_q, disp_d;

    logic             tick;
    logic [3:0]       nib;
    logic [6:0]       seg_dec;
    logic [6:0]       seg_sel;
    logic [3:0]       anode;
    logic             blank;

    assign tick = (cnt_q == CNT_W'(DWELL - 1));
    assign nib  = val_q[{idx_q, 2'b00} +: 4];

    seg7_decode u_decode (
        .nib_i (nib),
        .seg_o (seg_dec)
    );

    // Blank digit idx when it and every more-significant shadow digit are zero
    always_comb begin
        blank = 1'b0;
        if (BLANK_LZ) begin
            case (idx_q)
                2'd1:    blank = (val_q[15:4]  == 12'h000);
                2'd2:    blank = (val_q[15:8]  == 8'h00);
                2'd3:    blank = (val_q[15:12] == 4'h0);
                default: blank = 1'b0;
            endcase
        end
        seg_sel = blank ? SEG_OFF : seg_dec;
        anode   = ANODE_OFF ^ (4'b0001 << idx_q);
    end

    // Next-state: dwell counter, digit index, shadow capture, output word
    always_comb begin
        cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d  = tick ? idx_q + 2'd1 : idx_q;
        val_d  = LOAD ? VALUE : val_q;
        dp_d   = LOAD ? DP : dp_q;
        disp_d = tick ? {anode, seg_sel, ~dp_q[idx_q]} : disp_q;
    end

    // State registers; reset aborts the scan and clears the shadow copy
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt_q  <= '0;
            idx_q  <= 2'd0;
            val_q  <= 16'h0000;
            dp_q   <= 4'b0000;
            disp_q <= DISP_OFF;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            val_q  <= val_d;
            dp_q   <= dp_d;
            disp_q <= disp_d;
        end
    end

    assign DISP = disp_q;

endmodule
